// File: rtl/hwag_pkg.sv
// Shared types and constants for the HWAG crank tooth-period/sync path.
package hwag_pkg;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    ARM  = 2'd1,
    HUNT = 2'd2,
    SYNC = 2'd3
  } hwag_state_e;

  // All-ones timer ceiling; users slice it to their own timer width (up to 64).
  localparam logic [63:0] TMR_MAX = '1;

endpackage

// File: rtl/hwag_sat_timer.sv
// Saturating up-counter with synchronous load-to-1 and an at-ceiling flag.
module hwag_sat_timer #(
  parameter int WIDTH = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             load1_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             at_max_o
);
  import hwag_pkg::*;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             at_max;

  assign at_max = (cnt_q == TMR_MAX[WIDTH-1:0]);

  always_comb begin
    cnt_d = cnt_q;
    if (load1_i) begin
      cnt_d = WIDTH'(1);
    end else if (inc_i && !at_max) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign at_max_o = at_max;

endmodule

// File: rtl/hwag_tooth_period_sync.sv
// Tooth period measurement, missing-tooth gap detection and tooth index tracking
// for the crank trigger wheel, with wheel-stop detection on timer saturation.
module hwag_tooth_period_sync #(
  parameter int WIDTH  = 24,
  parameter int TEETH  = 58,
  parameter int TWIDTH = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              cap_edge,
  output logic [WIDTH-1:0]  per_cur,
  output logic [WIDTH-1:0]  per_prev,
  output logic [TWIDTH-1:0] tooth_cnt,
  output logic              sync,
  output logic              gap_det,
  output logic              err,
  output logic              ovf
);
  import hwag_pkg::*;

  localparam logic [TWIDTH-1:0] LAST_TOOTH = TWIDTH'(TEETH - 1);

  hwag_state_e       state_q, state_d;
  logic [WIDTH-1:0]  per_cur_q, per_cur_d;
  logic [WIDTH-1:0]  per_prev_q, per_prev_d;
  logic [TWIDTH-1:0] tooth_q, tooth_d;
  logic              ovf_q, ovf_d;
  logic              gap_det_q, gap_det_d;
  logic              err_q, err_d;

  logic [WIDTH-1:0]  tmr;
  logic              tmr_at_max;
  logic              gap;
  logic              edge_v;

  assign edge_v = ena && cap_edge;

  hwag_sat_timer #(.WIDTH(WIDTH)) u_tmr (
    .clk_i    (clk),
    .rst_i    (rst),
    .inc_i    (ena && (state_q != STOP)),
    .load1_i  (edge_v),
    .cnt_o    (tmr),
    .at_max_o (tmr_at_max)
  );

  // One extra bit so doubling the previous period never wraps.
  assign gap = ({1'b0, tmr} >= {per_cur_q, 1'b0});

  always_comb begin
    state_d    = state_q;
    per_cur_d  = per_cur_q;
    per_prev_d = per_prev_q;
    tooth_d    = tooth_q;
    ovf_d      = ovf_q;
    gap_det_d  = 1'b0;
    err_d      = 1'b0;

    if (edge_v) begin
      ovf_d = 1'b0;
      if (state_q != STOP) begin
        per_prev_d = per_cur_q;
        per_cur_d  = tmr;
      end
      unique case (state_q)
        STOP: state_d = ARM;
        ARM:  state_d = HUNT;
        HUNT: begin
          if (gap) begin
            state_d   = SYNC;
            tooth_d   = '0;
            gap_det_d = 1'b1;
          end
        end
        SYNC: begin
          if (tooth_q == LAST_TOOTH) begin
            tooth_d = '0;
            if (gap) begin
              gap_det_d = 1'b1;
            end else begin
              err_d   = 1'b1;
              state_d = HUNT;
            end
          end else if (gap) begin
            err_d   = 1'b1;
            state_d = HUNT;
            tooth_d = '0;
          end else begin
            tooth_d = tooth_q + TWIDTH'(1);
          end
        end
        default: state_d = STOP;
      endcase
    end else if (ena && (state_q != STOP) && tmr_at_max) begin
      ovf_d   = 1'b1;
      state_d = STOP;
      tooth_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= STOP;
      per_cur_q  <= '0;
      per_prev_q <= '0;
      tooth_q    <= '0;
      ovf_q      <= 1'b0;
      gap_det_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      per_cur_q  <= per_cur_d;
      per_prev_q <= per_prev_d;
      tooth_q    <= tooth_d;
      ovf_q      <= ovf_d;
      gap_det_q  <= gap_det_d;
      err_q      <= err_d;
    end
  end

  assign per_cur   = per_cur_q;
  assign per_prev  = per_prev_q;
  assign tooth_cnt = tooth_q;
  assign sync      = (state_q == SYNC);
  assign gap_det   = gap_det_q;
  assign err       = err_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_hwag_tooth_period_sync.sv
// Directed bench for hwag_tooth_period_sync at WIDTH=8, TEETH=4, TWIDTH=2.
module tb_hwag_tooth_period_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       cap_edge;
  logic [7:0] per_cur;
  logic [7:0] per_prev;
  logic [1:0] tooth_cnt;
  logic       sync;
  logic       gap_det;
  logic       err;
  logic       ovf;

  int n_checks = 0;
  int n_errors = 0;

  hwag_tooth_period_sync #(.WIDTH(8), .TEETH(4), .TWIDTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .cap_edge  (cap_edge),
    .per_cur   (per_cur),
    .per_prev  (per_prev),
    .tooth_cnt (tooth_cnt),
    .sync      (sync),
    .gap_det   (gap_det),
    .err       (err),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         sp;
    logic [7:0] pc;
    logic [7:0] pp;
    logic [1:0] tc;
    logic       sy;
    logic       gd;
    logic       er;
  } vec_t;

  vec_t tbl[24];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] pc, input logic [7:0] pp,
                         input logic [1:0] tc, input logic sy, input logic gd,
                         input logic er, input logic ov);
    chk({tag, ".per_cur"},   int'(per_cur),   int'(pc));
    chk({tag, ".per_prev"},  int'(per_prev),  int'(pp));
    chk({tag, ".tooth_cnt"}, int'(tooth_cnt), int'(tc));
    chk({tag, ".sync"},      int'(sync),      int'(sy));
    chk({tag, ".gap_det"},   int'(gap_det),   int'(gd));
    chk({tag, ".err"},       int'(err),       int'(er));
    chk({tag, ".ovf"},       int'(ovf),       int'(ov));
  endtask

  task automatic pulse_edge();
    cap_edge = 1'b1;
    tick();
    cap_edge = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           sp  per_cur per_prev tooth sync gap  err
    tbl[0]  = '{10, 8'd0,  8'd0,  2'd0, 1'b0, 1'b0, 1'b0};  // STOP->ARM
    tbl[1]  = '{10, 8'd10, 8'd0,  2'd0, 1'b0, 1'b0, 1'b0};  // ARM->HUNT
    tbl[2]  = '{10, 8'd10, 8'd10, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{10, 8'd10, 8'd10, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{25, 8'd25, 8'd10, 2'd0, 1'b1, 1'b1, 1'b0};  // first gap -> SYNC
    tbl[5]  = '{10, 8'd10, 8'd25, 2'd1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{10, 8'd10, 8'd10, 2'd2, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{10, 8'd10, 8'd10, 2'd3, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{25, 8'd25, 8'd10, 2'd0, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{10, 8'd10, 8'd25, 2'd1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{10, 8'd10, 8'd10, 2'd2, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{10, 8'd10, 8'd10, 2'd3, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{25, 8'd25, 8'd10, 2'd0, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{10, 8'd10, 8'd25, 2'd1, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{25, 8'd25, 8'd10, 2'd0, 1'b0, 1'b0, 1'b1};  // gap at tooth 1
    tbl[15] = '{10, 8'd10, 8'd25, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{10, 8'd10, 8'd10, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{25, 8'd25, 8'd10, 2'd0, 1'b1, 1'b1, 1'b0};
    tbl[18] = '{10, 8'd10, 8'd25, 2'd1, 1'b1, 1'b0, 1'b0};
    tbl[19] = '{10, 8'd10, 8'd10, 2'd2, 1'b1, 1'b0, 1'b0};
    tbl[20] = '{10, 8'd10, 8'd10, 2'd3, 1'b1, 1'b0, 1'b0};
    tbl[21] = '{10, 8'd10, 8'd10, 2'd0, 1'b0, 1'b0, 1'b1};  // missing gap
    tbl[22] = '{25, 8'd25, 8'd10, 2'd0, 1'b1, 1'b1, 1'b0};
    tbl[23] = '{10, 8'd10, 8'd25, 2'd1, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    ena = 1'b1;
    cap_edge = 1'b0;
    tick();
    tick();
    chk_all("reset", 8'd0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      for (int k = 0; k < tbl[i].sp - 1; k++) begin
        tick();
        if (k == 0) begin
          chk($sformatf("v%0d.pulse_width_gap", i), int'(gap_det), 0);
          chk($sformatf("v%0d.pulse_width_err", i), int'(err), 0);
        end
      end
      pulse_edge();
      chk_all($sformatf("v%0d", i), tbl[i].pc, tbl[i].pp, tbl[i].tc,
              tbl[i].sy, tbl[i].gd, tbl[i].er, 1'b0);
    end

    // Wheel stop: timer reaches 255 after 254 idle cycles, overflow the cycle after.
    for (int k = 0; k < 254; k++) tick();
    chk("pre_ovf.ovf", int'(ovf), 0);
    chk("pre_ovf.sync", int'(sync), 1);
    tick();
    chk_all("ovf", 8'd10, 8'd25, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) tick();
    chk("ovf_sticky", int'(ovf), 1);
    chk("ovf_stop_per_cur", int'(per_cur), 10);
    pulse_edge();
    chk_all("ovf_clear", 8'd10, 8'd25, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 11; k++) tick();
    pulse_edge();
    chk_all("rearm", 8'd12, 8'd10, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Edge coinciding with a saturated timer: captured, no overflow.
    for (int k = 0; k < 254; k++) tick();
    chk("sat_edge_pre.ovf", int'(ovf), 0);
    pulse_edge();
    chk_all("sat_edge", 8'd255, 8'd12, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Enable freeze mid-sync with edges ignored.
    for (int k = 0; k < 9; k++) tick();
    pulse_edge();
    chk_all("pre_freeze", 8'd10, 8'd255, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) tick();
    ena = 1'b0;
    for (int j = 0; j < 20; j++) begin
      cap_edge = ((j % 5) == 2);
      tick();
      if ((j % 5) == 3) begin
        chk_all($sformatf("freeze%0d", j), 8'd10, 8'd255, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      end
    end
    cap_edge = 1'b0;
    ena = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    pulse_edge();
    chk_all("post_freeze", 8'd10, 8'd10, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-revolution.
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all("mid_rst", 8'd0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
